serial_add_ctrl: RTL

Bit-serial add/subtract sequencer built around the team's `full_adder` cell. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and steps them LSB-first through one `full_adder` instance, one bit per clock, using a registered carry. It returns the WIDTH-bit result with carry-out and signed-overflow flags over a second valid/ready handshake. It is the arithmetic datapath scheduler for area-constrained paths where a ripple adder of full width is not wanted.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshakes of serial_add_ctrl; slave is the sequencer side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder evaluation per clock, LSB first,
// carry held in a register between bits.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_add_ctrl: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;

    logic fa_s;
    logic fa_co;
    logic done;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction folds into addition: invert B, seed the carry with 1.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB, needed for overflow.
                    cmsb_d  = carry_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
        end
    end

    // Result outputs are masked outside DONE so a partial result is never visible.
    assign done          = (state_q == DONE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = done;
    assign bus.sum       = done ? sum_sh_q : '0;
    assign bus.cout      = done & carry_q;
    assign bus.ovf       = done & (cmsb_q ^ carry_q);

endmodule
